// File: rtl/puf_eval_sequencer.sv
// Drives one challenge/PDL configuration into the PUF mapping stage and runs REPEATS
// reset/trigger/sample evaluations. Returns the majority vote, ones count, stability and raw-bit instability.
module puf_eval_sequencer #(
  parameter int CHALLENGE_WIDTH  = 32,
  parameter int PDL_CONFIG_WIDTH = 128,
  parameter int RESPONSE_WIDTH   = 6,
  parameter int REPEATS          = 15,
  parameter int RESET_CYCLES     = 4,
  parameter int SETTLE_CYCLES    = 8,
  parameter int COUNT_WIDTH      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHALLENGE_WIDTH-1:0]  in_challenge,
  input  logic [PDL_CONFIG_WIDTH-1:0] in_pdl_config,
  output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
  output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
  output logic                        puf_trigger,
  output logic                        puf_reset,
  input  logic [RESPONSE_WIDTH-1:0]   raw_response,
  input  logic                        xor_response,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_xor_bit,
  output logic [COUNT_WIDTH-1:0]      out_ones_count,
  output logic                        out_stable,
  output logic [RESPONSE_WIDTH-1:0]   out_raw_first,
  output logic [RESPONSE_WIDTH-1:0]   out_raw_mask
);

  localparam int CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(REPEATS + 1);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [COUNT_WIDTH-1:0]      ones_q, ones_d;
  logic [RESPONSE_WIDTH-1:0]   mask_q, mask_d;
  logic [RESPONSE_WIDTH-1:0]   first_q, first_d;
  logic [CHALLENGE_WIDTH-1:0]  chal_q, chal_d;
  logic [PDL_CONFIG_WIDTH-1:0] pdl_q, pdl_d;
  logic                        oxor_q, oxor_d;
  logic [COUNT_WIDTH-1:0]      oones_q, oones_d;
  logic                        ostable_q, ostable_d;
  logic [RESPONSE_WIDTH-1:0]   ofirst_q, ofirst_d;
  logic [RESPONSE_WIDTH-1:0]   omask_q, omask_d;

  logic [COUNT_WIDTH-1:0]      s_ones;
  logic [RESPONSE_WIDTH-1:0]   s_first;
  logic [RESPONSE_WIDTH-1:0]   s_mask;

  // Strict majority: an even-REPEATS tie resolves to 0.
  function automatic logic vote_majority(input logic [COUNT_WIDTH-1:0] n);
    return n > COUNT_WIDTH'(REPEATS / 2);
  endfunction

  function automatic logic vote_stable(input logic [COUNT_WIDTH-1:0] n);
    return (n == '0) || (n == COUNT_WIDTH'(REPEATS));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      ones_q    <= '0;
      mask_q    <= '0;
      first_q   <= '0;
      chal_q    <= '0;
      pdl_q     <= '0;
      oxor_q    <= 1'b0;
      oones_q   <= '0;
      ostable_q <= 1'b0;
      ofirst_q  <= '0;
      omask_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ones_q    <= ones_d;
      mask_q    <= mask_d;
      first_q   <= first_d;
      chal_q    <= chal_d;
      pdl_q     <= pdl_d;
      oxor_q    <= oxor_d;
      oones_q   <= oones_d;
      ostable_q <= ostable_d;
      ofirst_q  <= ofirst_d;
      omask_q   <= omask_d;
    end
  end

  // Accumulated values including the sample captured on this cycle's closing edge.
  always_comb begin
    s_ones  = ones_q + COUNT_WIDTH'(xor_response);
    s_first = (idx_q == '0) ? raw_response : first_q;
    s_mask  = (idx_q == '0) ? '0 : (mask_q | (first_q ^ raw_response));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ones_d    = ones_q;
    mask_d    = mask_q;
    first_d   = first_q;
    chal_d    = chal_q;
    pdl_d     = pdl_q;
    oxor_d    = oxor_q;
    oones_d   = oones_q;
    ostable_d = ostable_q;
    ofirst_d  = ofirst_q;
    omask_d   = omask_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          chal_d  = in_challenge;
          pdl_d   = in_pdl_config;
          ones_d  = '0;
          mask_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        ones_d  = s_ones;
        first_d = s_first;
        mask_d  = s_mask;
        idx_d   = idx_q + 1'b1;
        cnt_d   = '0;
        if (idx_q == IDX_W'(REPEATS - 1)) begin
          oxor_d    = vote_majority(s_ones);
          oones_d   = s_ones;
          ostable_d = vote_stable(s_ones);
          ofirst_d  = s_first;
          omask_d   = s_mask;
          state_d   = DONE;
        end else begin
          state_d = ARM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    puf_trigger = (state_q == FIRE) || (state_q == SAMPLE);
    puf_reset   = !puf_trigger;
  end

  assign puf_challenge  = chal_q;
  assign puf_pdl_config = pdl_q;
  assign out_xor_bit    = oxor_q;
  assign out_ones_count = oones_q;
  assign out_stable     = ostable_q;
  assign out_raw_first  = ofirst_q;
  assign out_raw_mask   = omask_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench: two sequencer instances (REPEATS=3 and REPEATS=4, RESET_CYCLES=2, SETTLE_CYCLES=3)
// driven with hand-computed response patterns.
module tb_puf_eval_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, iv3, iv4, out_ready, xr, sel;
  logic [31:0]  in_chal;
  logic [127:0] in_pdl;
  logic [5:0]   raw;

  logic         r3_ird, r3_trig, r3_prst, r3_vld, r3_xb, r3_stb;
  logic [31:0]  r3_chal;
  logic [127:0] r3_pdl;
  logic [4:0]   r3_ones;
  logic [5:0]   r3_first, r3_mask;
  logic         r4_ird, r4_trig, r4_prst, r4_vld, r4_xb, r4_stb;
  logic [31:0]  r4_chal;
  logic [127:0] r4_pdl;
  logic [4:0]   r4_ones;
  logic [5:0]   r4_first, r4_mask;

  int n_chk  = 0;
  int n_fail = 0;

  puf_eval_sequencer #(.REPEATS(3), .RESET_CYCLES(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(r3_ird),
    .in_challenge(in_chal), .in_pdl_config(in_pdl),
    .puf_challenge(r3_chal), .puf_pdl_config(r3_pdl),
    .puf_trigger(r3_trig), .puf_reset(r3_prst),
    .raw_response(raw), .xor_response(xr),
    .out_valid(r3_vld), .out_ready(out_ready), .out_xor_bit(r3_xb),
    .out_ones_count(r3_ones), .out_stable(r3_stb),
    .out_raw_first(r3_first), .out_raw_mask(r3_mask)
  );

  puf_eval_sequencer #(.REPEATS(4), .RESET_CYCLES(2), .SETTLE_CYCLES(3)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(r4_ird),
    .in_challenge(in_chal), .in_pdl_config(in_pdl),
    .puf_challenge(r4_chal), .puf_pdl_config(r4_pdl),
    .puf_trigger(r4_trig), .puf_reset(r4_prst),
    .raw_response(raw), .xor_response(xr),
    .out_valid(r4_vld), .out_ready(out_ready), .out_xor_bit(r4_xb),
    .out_ones_count(r4_ones), .out_stable(r4_stb),
    .out_raw_first(r4_first), .out_raw_mask(r4_mask)
  );

  logic         o_ird, o_trig, o_prst, o_vld, o_xb, o_stb;
  logic [31:0]  o_chal;
  logic [127:0] o_pdl;
  logic [4:0]   o_ones;
  logic [5:0]   o_first, o_mask;

  always_comb begin
    o_ird   = sel ? r4_ird   : r3_ird;
    o_trig  = sel ? r4_trig  : r3_trig;
    o_prst  = sel ? r4_prst  : r3_prst;
    o_vld   = sel ? r4_vld   : r3_vld;
    o_xb    = sel ? r4_xb    : r3_xb;
    o_stb   = sel ? r4_stb   : r3_stb;
    o_chal  = sel ? r4_chal  : r3_chal;
    o_pdl   = sel ? r4_pdl   : r3_pdl;
    o_ones  = sel ? r4_ones  : r3_ones;
    o_first = sel ? r4_first : r3_first;
    o_mask  = sel ? r4_mask  : r3_mask;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_result(input logic [4:0] ones, input logic xb, input logic stb,
                            input logic [5:0] first, input logic [5:0] mask);
    chk("out_valid", o_vld, 1'b1);
    chk("out_ones_count", o_ones, ones);
    chk("out_xor_bit", o_xb, xb);
    chk("out_stable", o_stb, stb);
    chk("out_raw_first", o_first, first);
    chk("out_raw_mask", o_mask, mask);
  endtask

  // Period per evaluation is RESET_CYCLES+SETTLE_CYCLES+1 = 6; cycle c is the interval after edge c-1.
  task automatic run_txn(input logic s, input logic [31:0] chal, input int nrep,
                         input logic [3:0] xs, input logic [23:0] rs, input bit tog, input int stop_c);
    int k, ph;
    sel = s;
    @(negedge clk);
    in_chal = chal;
    in_pdl  = {4{chal}};
    if (s) iv4 = 1'b1; else iv3 = 1'b1;
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    iv4 = 1'b0;
    for (int c = 1; c <= nrep * 6 + 1; c++) begin
      @(negedge clk);
      if (stop_c != 0 && c == stop_c) return;
      k  = (c - 1) / 6;
      ph = (c - 1) % 6;
      if (k < nrep) begin
        xr  = xs[k];
        raw = rs[k*6 +: 6];
      end
      if (tog) in_chal = ~in_chal;
      chk("puf_trigger", o_trig, (k < nrep) && (ph >= 2));
      chk("puf_reset", o_prst, !((k < nrep) && (ph >= 2)));
      chk("out_valid timing", o_vld, c == nrep * 6 + 1);
      chk("in_ready busy", o_ird, 1'b0);
      chk("puf_challenge held", o_chal, chal);
    end
    chk("puf_pdl_config", o_pdl, {4{chal}});
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid after handshake", o_vld, 1'b0);
    chk("in_ready after handshake", o_ird, 1'b1);
  endtask

  initial begin
    reset = 1'b0; iv3 = 1'b0; iv4 = 1'b0; out_ready = 1'b0; xr = 1'b0; sel = 1'b0;
    in_chal = '0; in_pdl = '0; raw = '0;

    // Reset asserted mid-cycle.
    #3 reset = 1'b1;
    #1;
    chk("rst puf_reset", o_prst, 1'b1);
    chk("rst puf_trigger", o_trig, 1'b0);
    chk("rst out_valid", o_vld, 1'b0);
    chk("rst in_ready", o_ird, 1'b1);
    chk("rst puf_challenge", o_chal, 32'h0);
    chk("rst puf_pdl_config", o_pdl, 128'h0);
    chk("rst ones", o_ones, 5'd0);
    chk("rst xor_bit", o_xb, 1'b0);
    chk("rst stable", o_stb, 1'b0);
    chk("rst raw_first", o_first, 6'h0);
    chk("rst raw_mask", o_mask, 6'h0);
    chk("rst dut4 in_ready", r4_ird, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Steady PUF, in_challenge toggling during the transaction.
    run_txn(1'b0, 32'hDEADBEEF, 3, 4'b0111, {6'h00, 6'h2A, 6'h2A, 6'h2A}, 1'b1, 0);
    chk_result(5'd3, 1'b1, 1'b1, 6'h2A, 6'h00);
    handshake();

    // Noisy PUF, then backpressure with an ignored in_valid pulse.
    run_txn(1'b0, 32'hCAFE0001, 3, 4'b0101, {6'h00, 6'h2A, 6'h2B, 6'h2A}, 1'b0, 0);
    chk_result(5'd2, 1'b1, 1'b0, 6'h2A, 6'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_chal = 32'h12345678;
        iv3 = 1'b1;
      end
      if (i == 4) iv3 = 1'b0;
      chk("bp in_ready", o_ird, 1'b0);
      chk("bp puf_challenge", o_chal, 32'hCAFE0001);
      chk_result(5'd2, 1'b1, 1'b0, 6'h2A, 6'h01);
    end
    handshake();
    chk("results kept after handshake", o_mask, 6'h01);

    // Even-REPEATS tie.
    run_txn(1'b1, 32'h0BADF00D, 4, 4'b0011, {4{6'h15}}, 1'b0, 0);
    chk_result(5'd2, 1'b0, 1'b0, 6'h15, 6'h00);
    handshake();

    // Reset during the second evaluation's FIRE phase.
    run_txn(1'b0, 32'h55AA55AA, 3, 4'b0111, {4{6'h2A}}, 1'b0, 10);
    chk("pre-reset trigger", o_trig, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst puf_trigger", o_trig, 1'b0);
    chk("midrst puf_reset", o_prst, 1'b1);
    chk("midrst out_valid", o_vld, 1'b0);
    chk("midrst in_ready", o_ird, 1'b1);
    chk("midrst puf_challenge", o_chal, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(1'b0, 32'h13579BDF, 3, 4'b0000, {4{6'h2A}}, 1'b0, 0);
    chk_result(5'd0, 1'b0, 1'b1, 6'h2A, 6'h00);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
